// File: rtl/rv32_regfile_mp.sv
// Multi-port RV32 register file: 2 write ports, NRP combinational read ports, pending scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining RV32_REGFILE_BYPASS_EN.
module rv32_regfile_mp #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRP   = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [1:0]          we_i,
    input  logic [2*AW-1:0]     rd_addr_i,
    input  logic [2*XLEN-1:0]   val_rd_i,
    input  logic [NRP*AW-1:0]   rs_addr_i,
    output logic [NRP*XLEN-1:0] val_rs_o,
    output logic [NRP-1:0]      busy_o,
    input  logic                issue_i,
    input  logic [AW-1:0]       issue_addr_i,
    input  logic                flush_i
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_d;

    logic [AW-1:0]    w_waddr [2];
    logic [XLEN-1:0]  w_wdata [2];
    logic [1:0]       w_wact;

    // Writes to x0 are never active, so x0 keeps its reset value forever.
    for (genvar p = 0; p < 2; p++) begin : g_wport
        assign w_waddr[p] = rd_addr_i[p*AW +: AW];
        assign w_wdata[p] = val_rd_i[p*XLEN +: XLEN];
        assign w_wact[p]  = we_i[p] && (w_waddr[p] != '0);
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_regs[g] <= '0;
            end else if (w_wact[1] && (w_waddr[1] == AW'(g))) begin
                r_regs[g] <= w_wdata[1];
            end else if (w_wact[0] && (w_waddr[0] == AW'(g))) begin
                r_regs[g] <= w_wdata[0];
            end
        end
    end

    // Issue overrides a same-edge write clear; flush overrides everything.
    always_comb begin
        w_pend_d = r_pend;
        for (int unsigned i = 1; i < NREGS; i++) begin
            if (w_wact[0] && (w_waddr[0] == AW'(i))) begin
                w_pend_d[i] = 1'b0;
            end
            if (w_wact[1] && (w_waddr[1] == AW'(i))) begin
                w_pend_d[i] = 1'b0;
            end
            if (issue_i && (issue_addr_i == AW'(i))) begin
                w_pend_d[i] = 1'b1;
            end
        end
        w_pend_d[0] = 1'b0;
        if (flush_i) begin
            w_pend_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_d;
        end
    end

    for (genvar k = 0; k < NRP; k++) begin : g_rport
        logic [AW-1:0]   w_raddr;
        logic [XLEN-1:0] w_rval;
        logic            w_rbusy;

        assign w_raddr = rs_addr_i[k*AW +: AW];

        always_comb begin
            w_rval  = r_regs[w_raddr];
            w_rbusy = r_pend[w_raddr];
`ifdef RV32_REGFILE_BYPASS_EN
            if (w_wact[1] && (w_waddr[1] == w_raddr)) begin
                w_rval  = w_wdata[1];
                w_rbusy = 1'b0;
            end else if (w_wact[0] && (w_waddr[0] == w_raddr)) begin
                w_rval  = w_wdata[0];
                w_rbusy = 1'b0;
            end
`endif
        end

        // Gate with reset so a bypassed write cannot leak out while reset is held.
        assign val_rs_o[k*XLEN +: XLEN] = rst_n_i ? w_rval : '0;
        assign busy_o[k]                = rst_n_i & w_rbusy;
    end

endmodule

// File: tb/tb_rv32_regfile_mp.sv
// Directed self-checking bench for rv32_regfile_mp (XLEN=32, NREGS=32, NRP=2).
module tb_rv32_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [1:0]  we;
    logic [9:0]  rd_addr;
    logic [63:0] val_rd;
    logic [9:0]  rs_addr;
    logic [63:0] val_rs;
    logic [1:0]  busy;
    logic        issue;
    logic [4:0]  issue_addr;
    logic        flush;

    int checks = 0;
    int errors = 0;

    rv32_regfile_mp #(
        .XLEN  (32),
        .NREGS (32),
        .NRP   (2)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .we_i         (we),
        .rd_addr_i    (rd_addr),
        .val_rd_i     (val_rd),
        .rs_addr_i    (rs_addr),
        .val_rs_o     (val_rs),
        .busy_o       (busy),
        .issue_i      (issue),
        .issue_addr_i (issue_addr),
        .flush_i      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        we         = 2'b11;
        rd_addr    = {5'd6, 5'd5};
        val_rd     = {32'd11, 32'd22};
        issue      = 1'b1;
        issue_addr = 5'd5;
        tick();
        tick();
        for (int a = 0; a < 32; a++) begin
            rs_addr = {a[4:0], a[4:0]};
            #1;
            checks++;
            if (val_rs !== 64'd0 || busy !== 2'b00) begin
                errors++;
                $display("FAIL reset_read x%0d got val=%h busy=%b want 0/00", a, val_rs, busy);
            end
        end
        we    = 2'b00;
        issue = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        rs_addr = {5'd6, 5'd5};
        #1;
        checks++;
        if (val_rs !== 64'd0 || busy !== 2'b00) begin
            errors++;
            $display("FAIL reset_ignored_wr got val=%h busy=%b want 0/00", val_rs, busy);
        end
    endtask

    task automatic test_write_all();
        logic [31:0] exp0;
        logic [31:0] exp1;
        for (int i = 1; i < 32; i++) begin
            we      = 2'b01;
            rd_addr = {5'd0, i[4:0]};
            val_rd  = {32'd0, 32'((i + 1) * 12)};
            tick();
        end
        we = 2'b00;
        for (int a = 0; a < 32; a++) begin
            rs_addr = {5'(31 - a), a[4:0]};
            exp0    = (a == 0) ? 32'd0 : 32'((a + 1) * 12);
            exp1    = (a == 31) ? 32'd0 : 32'((32 - a) * 12);
            #1;
            checks++;
            if (val_rs[31:0] !== exp0 || val_rs[63:32] !== exp1) begin
                errors++;
                $display("FAIL write_all a=%0d got %0d/%0d want %0d/%0d",
                         a, val_rs[31:0], val_rs[63:32], exp0, exp1);
            end
        end
        rs_addr = {5'd31, 5'd5};
        #1;
        checks++;
        if (val_rs[31:0] !== 32'd72 || val_rs[63:32] !== 32'd384) begin
            errors++;
            $display("FAIL x5_x31 got %0d/%0d want 72/384", val_rs[31:0], val_rs[63:32]);
        end
    endtask

    task automatic test_same_addr();
        we      = 2'b11;
        rd_addr = {5'd3, 5'd3};
        val_rd  = {32'd777, 32'd546};
        tick();
        we      = 2'b00;
        rs_addr = {5'd3, 5'd3};
        #1;
        checks++;
        if (val_rs !== {32'd777, 32'd777}) begin
            errors++;
            $display("FAIL same_addr_x3 got %0d/%0d want 777/777", val_rs[31:0], val_rs[63:32]);
        end
        we      = 2'b11;
        rd_addr = {5'd0, 5'd0};
        val_rd  = {32'd654, 32'd654};
        tick();
        we      = 2'b00;
        rs_addr = {5'd0, 5'd0};
        #1;
        checks++;
        if (val_rs !== 64'd0 || busy !== 2'b00) begin
            errors++;
            $display("FAIL x0_write got val=%h busy=%b want 0/00", val_rs, busy);
        end
        we      = 2'b11;
        rd_addr = {5'd10, 5'd2};
        val_rd  = {32'd4321, 32'd1234};
        tick();
        we      = 2'b00;
        rs_addr = {5'd10, 5'd2};
        #1;
        checks++;
        if (val_rs[31:0] !== 32'd1234 || val_rs[63:32] !== 32'd4321) begin
            errors++;
            $display("FAIL dual_write got %0d/%0d want 1234/4321", val_rs[31:0], val_rs[63:32]);
        end
    endtask

    task automatic test_scoreboard();
        rs_addr    = {5'd7, 5'd7};
        issue      = 1'b1;
        issue_addr = 5'd7;
        #1;
        checks++;
        if (busy !== 2'b00) begin
            errors++;
            $display("FAIL issue_pre_edge got busy=%b want 00", busy);
        end
        tick();
        issue = 1'b0;
        #1;
        checks++;
        if (busy !== 2'b11) begin
            errors++;
            $display("FAIL issue_x7 got busy=%b want 11", busy);
        end
        we      = 2'b01;
        rd_addr = {5'd0, 5'd7};
        val_rd  = {32'd0, 32'd9};
        tick();
        we = 2'b00;
        #1;
        checks++;
        if (busy !== 2'b00 || val_rs[31:0] !== 32'd9) begin
            errors++;
            $display("FAIL write_clears got busy=%b val=%0d want 00/9", busy, val_rs[31:0]);
        end
        issue   = 1'b1;
        we      = 2'b10;
        rd_addr = {5'd7, 5'd0};
        val_rd  = {32'd10, 32'd0};
        tick();
        issue = 1'b0;
        we    = 2'b00;
        #1;
        checks++;
        if (busy !== 2'b11 || val_rs[31:0] !== 32'd10) begin
            errors++;
            $display("FAIL issue_wins got busy=%b val=%0d want 11/10", busy, val_rs[31:0]);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checks++;
        if (busy !== 2'b00 || val_rs[31:0] !== 32'd10) begin
            errors++;
            $display("FAIL flush got busy=%b val=%0d want 00/10", busy, val_rs[31:0]);
        end
        flush = 1'b1;
        issue = 1'b1;
        tick();
        flush = 1'b0;
        issue = 1'b0;
        #1;
        checks++;
        if (busy !== 2'b00) begin
            errors++;
            $display("FAIL flush_over_issue got busy=%b want 00", busy);
        end
        issue      = 1'b1;
        issue_addr = 5'd0;
        rs_addr    = {5'd0, 5'd0};
        tick();
        issue = 1'b0;
        #1;
        checks++;
        if (busy !== 2'b00) begin
            errors++;
            $display("FAIL x0_busy got busy=%b want 00", busy);
        end
        issue      = 1'b1;
        issue_addr = 5'd8;
        rs_addr    = {5'd8, 5'd7};
        tick();
        issue = 1'b0;
        #1;
        checks++;
        if (busy !== 2'b10) begin
            errors++;
            $display("FAIL issue_x8 got busy=%b want 10", busy);
        end
        we      = 2'b10;
        rd_addr = {5'd8, 5'd0};
        val_rd  = {32'd88, 32'd0};
        tick();
        we = 2'b00;
        #1;
        checks++;
        if (busy !== 2'b00 || val_rs[63:32] !== 32'd88) begin
            errors++;
            $display("FAIL port1_clears got busy=%b val=%0d want 00/88", busy, val_rs[63:32]);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_v;
        logic [1:0]  exp_b;
        issue      = 1'b1;
        issue_addr = 5'd4;
        tick();
        issue   = 1'b0;
        rs_addr = {5'd4, 5'd4};
        we      = 2'b01;
        rd_addr = {5'd0, 5'd4};
        val_rd  = {32'd0, 32'hDEAD};
`ifdef RV32_REGFILE_BYPASS_EN
        exp_v = 32'hDEAD;
        exp_b = 2'b00;
`else
        exp_v = 32'd60;
        exp_b = 2'b11;
`endif
        #1;
        checks++;
        if (val_rs !== {exp_v, exp_v} || busy !== exp_b) begin
            errors++;
            $display("FAIL bypass_same_cycle got val=%h busy=%b want %h/%b",
                     val_rs, busy, exp_v, exp_b);
        end
        tick();
        we = 2'b00;
        #1;
        checks++;
        if (val_rs !== {32'hDEAD, 32'hDEAD} || busy !== 2'b00) begin
            errors++;
            $display("FAIL bypass_after_edge got val=%h busy=%b want dead/00", val_rs, busy);
        end
        we      = 2'b11;
        rd_addr = {5'd4, 5'd4};
        val_rd  = {32'hBEEF, 32'hCAFE};
`ifdef RV32_REGFILE_BYPASS_EN
        exp_v = 32'hBEEF;
`else
        exp_v = 32'hDEAD;
`endif
        #1;
        checks++;
        if (val_rs[31:0] !== exp_v) begin
            errors++;
            $display("FAIL bypass_priority got %h want %h", val_rs[31:0], exp_v);
        end
        tick();
        we = 2'b00;
        #1;
        checks++;
        if (val_rs[31:0] !== 32'hBEEF) begin
            errors++;
            $display("FAIL dual_write_x4 got %h want beef", val_rs[31:0]);
        end
    endtask

    task automatic test_async_reset();
        issue      = 1'b1;
        issue_addr = 5'd9;
        tick();
        issue   = 1'b0;
        rs_addr = {5'd9, 5'd31};
        #1;
        checks++;
        if (val_rs[31:0] !== 32'd384 || val_rs[63:32] !== 32'd120 || busy !== 2'b10) begin
            errors++;
            $display("FAIL pre_async_reset got %0d/%0d busy=%b want 384/120/10",
                     val_rs[31:0], val_rs[63:32], busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (val_rs !== 64'd0 || busy !== 2'b00) begin
            errors++;
            $display("FAIL async_reset got val=%h busy=%b want 0/00", val_rs, busy);
        end
        rst_n = 1'b1;
        tick();
        #1;
        checks++;
        if (val_rs !== 64'd0 || busy !== 2'b00) begin
            errors++;
            $display("FAIL post_reset got val=%h busy=%b want 0/00", val_rs, busy);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        we         = 2'b00;
        rd_addr    = '0;
        val_rd     = '0;
        rs_addr    = '0;
        issue      = 1'b0;
        issue_addr = '0;
        flush      = 1'b0;
        test_reset();
        test_write_all();
        test_same_addr();
        test_scoreboard();
        test_bypass();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_regfile_mp.md
RV32_REGFILE_MP -- requirements
Module: rv32_regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; legal values 16 (RV32E) or 32; AW = log2(NREGS).
REQ-003 SHALL have parameter NRP, default 2, read-port count, range 1..4.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port we_i  input  2  write enable per write port (bit 0 = port 0, bit 1 = port 1).
REQ-007 SHALL have port rd_addr_i  input  2*AW  write addresses, port p at bits [p*AW +: AW].
REQ-008 SHALL have port val_rd_i  input  2*XLEN  write data, port p at bits [p*XLEN +: XLEN].
REQ-009 SHALL have port rs_addr_i  input  NRP*AW  read addresses, packed per port.
REQ-010 SHALL have port val_rs_o  output  NRP*XLEN  read data, packed per port.
REQ-011 SHALL have port busy_o  output  NRP  scoreboard busy flag of each read address.
REQ-012 SHALL have port issue_i  input  1  mark issue_addr_i pending.
REQ-013 SHALL have port issue_addr_i  input  AW  destination register being issued.
REQ-014 SHALL have port flush_i  input  1  clear all pending flags.

Function
REQ-015 Register 0 SHALL always read 0; writes to address 0 SHALL be discarded; register 0 SHALL never be busy.
REQ-016 Writes SHALL commit on the rising edge of clk_i when the corresponding we_i bit is 1.
REQ-017 Reads SHALL be combinational: val_rs_o reflects register contents with zero cycles of latency.
REQ-018 When both write ports target the same nonzero address in one cycle, port 1 data SHALL be stored.
REQ-019 Addresses >= NREGS (possible only when NREGS=16 with a 5-bit source) SHALL NOT exist; AW bounds them, so no wrap handling is required.
REQ-020 Scoreboard: one pending bit per register; issue_i=1 SHALL set bit issue_addr_i on the clock edge.
REQ-021 A write on either port SHALL clear the pending bit of its address on the same edge.
REQ-022 A simultaneous issue and write to the same address SHALL leave the bit set (issue wins).
REQ-023 flush_i=1 SHALL clear all pending bits on the edge and take priority over issue_i.
REQ-024 busy_o[k] SHALL equal the pending bit of rs_addr_i port k, combinationally; this value is before bypass is considered.
REQ-025 Data registers SHALL NOT be affected by flush_i.

Reset
REQ-026 rst_n_i low SHALL asynchronously clear all registers to 0 and all pending bits to 0; val_rs_o = 0 and busy_o = 0 while reset is held.
REQ-027 Writes or issues presented during reset SHALL be ignored; normal operation SHALL begin on the first rising edge after rst_n_i deasserts.

Configuration
REQ-028 Macro RV32_REGFILE_BYPASS_EN defined: a read port whose address matches an active same-cycle write SHALL return the incoming data (port 1 over port 0), and busy_o for that port SHALL read 0.
REQ-029 Macro RV32_REGFILE_BYPASS_EN undefined: reads SHALL return pre-edge contents, and busy_o SHALL be the raw pending bit.

Verification
REQ-030 Reset, then read all NREGS addresses on every port -> all 0, busy_o=0.
REQ-031 Write (i+1)*12 to x1..x31 via port 0, then read back -> x5=72, x31=384, x0=0.
REQ-032 Same cycle: port0 writes x3=546 and port1 writes x3=777, then read x3 -> 777; write x0=654 -> x0 reads 0.
REQ-033 Issue x7, then read x7 -> busy=1; write x7=9 -> busy=0 next cycle; issue+write x7 same cycle -> busy stays 1; flush -> busy=0.
REQ-034 With bypass: write x4=0xDEAD while reading x4 -> 0xDEAD in same cycle, busy 0; without bypass -> old value, then 0xDEAD after the edge.
REQ-035 Assert rst_n_i mid-sequence between edges -> val_rs_o and busy_o go to 0 immediately, without waiting for a clock edge.
